// File: rtl/ram_16x4_ctl.sv
// Access controller for a 16x4 asynchronous-write register RAM: valid/ready requests,
// active-low cs/we strobes with setup/hold cycles. Optional power-up clear: RAM16X4_CTL_INIT_EN.
module ram_16x4_ctl #(
  parameter int STROBE_CYC = 1
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [3:0] req_adr,
  input  logic [3:0] req_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_data,
  output logic       rd_valid,
  output logic [3:0] rd_data,
  output logic       rd_last,
  output logic       busy,
  output logic       adr0,
  output logic       adr1,
  output logic       adr2,
  output logic       adr3,
  output logic       wd0,
  output logic       wd1,
  output logic       wd2,
  output logic       wd3,
  input  logic       rd0,
  input  logic       rd1,
  input  logic       rd2,
  input  logic       rd3,
  output logic       cs,
  output logic       we
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_WAIT   = 3'd1,
    W_SETUP  = 3'd2,
    W_STROBE = 3'd3,
    W_HOLD   = 3'd4,
    R_ADDR   = 3'd5,
    R_SAMPLE = 3'd6
`ifdef RAM16X4_CTL_INIT_EN
    , INIT   = 3'd7
`endif
  } state_t;

  localparam logic [1:0] STB_LAST = 2'(STROBE_CYC - 1);

  state_t     state_r;
  logic [3:0] adr_r;
  logic [3:0] len_r;
  logic [3:0] wd_r;
  logic [1:0] stb_r;
`ifdef RAM16X4_CTL_INIT_EN
  logic       init_r;
`endif

  assign {adr3, adr2, adr1, adr0} = adr_r;
  assign {wd3, wd2, wd1, wd0}     = wd_r;

  // Access sequencer; every output is a register updated with the state it belongs to.
  always_ff @(posedge clkin) begin
    if (reset) begin
`ifdef RAM16X4_CTL_INIT_EN
      state_r   <= INIT;
      init_r    <= 1'b0;
`else
      state_r   <= IDLE;
`endif
      adr_r     <= 4'd0;
      len_r     <= 4'd0;
      wd_r      <= 4'd0;
      stb_r     <= 2'd0;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 4'd0;
      rd_last   <= 1'b0;
      busy      <= 1'b0;
      cs        <= 1'b1;
      we        <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            adr_r     <= req_adr;
            len_r     <= req_len;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_wr) begin
              wr_ready <= 1'b1;
              state_r  <= W_WAIT;
            end else begin
              cs      <= 1'b0;
              state_r <= R_ADDR;
            end
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cs        <= 1'b1;
            we        <= 1'b1;
          end
        end
        W_WAIT: begin
          if (wr_valid) begin
            wd_r     <= wr_data;
            wr_ready <= 1'b0;
            cs       <= 1'b0;
            state_r  <= W_SETUP;
          end else begin
            wr_ready <= 1'b1;
          end
        end
        W_SETUP: begin
          we      <= 1'b0;
          stb_r   <= STB_LAST;
          state_r <= W_STROBE;
        end
        W_STROBE: begin
          if (stb_r == 2'd0) begin
            we      <= 1'b1;
            state_r <= W_HOLD;
          end else begin
            stb_r <= stb_r - 2'd1;
          end
        end
        W_HOLD: begin
`ifdef RAM16X4_CTL_INIT_EN
          // The clear sweep chains words back-to-back without a handshake.
          if (init_r) begin
            if (adr_r == 4'd15) begin
              init_r    <= 1'b0;
              cs        <= 1'b1;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state_r   <= IDLE;
            end else begin
              adr_r   <= adr_r + 4'd1;
              state_r <= W_SETUP;
            end
          end else
`endif
          if (len_r == 4'd0) begin
            cs        <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            len_r    <= len_r - 4'd1;
            adr_r    <= adr_r + 4'd1;
            cs       <= 1'b1;
            wr_ready <= 1'b1;
            state_r  <= W_WAIT;
          end
        end
        R_ADDR: begin
          state_r <= R_SAMPLE;
        end
        R_SAMPLE: begin
          rd_data  <= {rd3, rd2, rd1, rd0};
          rd_valid <= 1'b1;
          rd_last  <= (len_r == 4'd0);
          if (len_r == 4'd0) begin
            cs        <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            len_r   <= len_r - 4'd1;
            adr_r   <= adr_r + 4'd1;
            state_r <= R_ADDR;
          end
        end
`ifdef RAM16X4_CTL_INIT_EN
        INIT: begin
          init_r  <= 1'b1;
          busy    <= 1'b1;
          adr_r   <= 4'd0;
          wd_r    <= 4'd0;
          cs      <= 1'b0;
          we      <= 1'b1;
          state_r <= W_SETUP;
        end
`endif
        default: begin
          cs        <= 1'b1;
          we        <= 1'b1;
          wr_ready  <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_16x4_ctl.sv
// Scoreboard bench for ram_16x4_ctl: a behavioural 16x4 RAM, a strobe-protocol monitor,
// and a second instance with STROBE_CYC=3.
module tb_ram_16x4_ctl;

  logic       clkin = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_wr;
  logic [3:0] req_adr, req_len;
  logic       wr_valid, wr_ready;
  logic [3:0] wr_data;
  logic       rd_valid, rd_last, busy, cs, we;
  logic [3:0] rd_data, adr_b, wd_b, rd_b;

  logic       req_valid3, req_ready3, req_wr3, wr_valid3, wr_ready3;
  logic [3:0] req_adr3, req_len3, wr_data3, rd_data3, adr_b3, wd_b3;
  logic       rd_valid3, rd_last3, busy3, cs3, we3;

  logic [3:0] mem [16];
  logic [3:0] exp_mem [16];
  logic [3:0] wbuf [16];
  logic [4:0] exp_q [$];

  int   tests = 0;
  int   fails = 0;
  logic rst_q = 1'b1;
  logic p_we = 1'b1, p_cs = 1'b1;
  logic [3:0] p_adr = 4'd0, p_wd = 4'd0;
  int   we_run = 0, last_we_len = 0, we_pulses = 0;
  int   run3 = 0, last3 = 0, pulses3 = 0, rdp3 = 0;

  always #5 clkin = ~clkin;

  ram_16x4_ctl #(.STROBE_CYC(1)) u_dut (
    .clkin(clkin), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_adr(req_adr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .adr0(adr_b[0]), .adr1(adr_b[1]), .adr2(adr_b[2]), .adr3(adr_b[3]),
    .wd0(wd_b[0]), .wd1(wd_b[1]), .wd2(wd_b[2]), .wd3(wd_b[3]),
    .rd0(rd_b[0]), .rd1(rd_b[1]), .rd2(rd_b[2]), .rd3(rd_b[3]),
    .cs(cs), .we(we)
  );

  ram_16x4_ctl #(.STROBE_CYC(3)) u_dut3 (
    .clkin(clkin), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_wr(req_wr3),
    .req_adr(req_adr3), .req_len(req_len3),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_data(wr_data3),
    .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_last(rd_last3), .busy(busy3),
    .adr0(adr_b3[0]), .adr1(adr_b3[1]), .adr2(adr_b3[2]), .adr3(adr_b3[3]),
    .wd0(wd_b3[0]), .wd1(wd_b3[1]), .wd2(wd_b3[2]), .wd3(wd_b3[3]),
    .rd0(1'b0), .rd1(1'b0), .rd2(1'b0), .rd3(1'b0),
    .cs(cs3), .we(we3)
  );

  // Behavioural RAM: write while cs and we are both low, combinational read.
  always @(negedge clkin) if (!cs && !we) mem[adr_b] <= wd_b;
  assign rd_b = mem[adr_b];

  always @(posedge clkin) rst_q <= reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe protocol monitor and read-data scoreboard for the STROBE_CYC=1 instance.
  always @(negedge clkin) begin
    if (!rst_q) begin
      if (!we) begin
        chk("cs_during_we", cs, 1'b0);
        chk("strobe_stable", {adr_b, wd_b}, {p_adr, p_wd});
        if (p_we) chk("cs_before_we", p_cs, 1'b0);
        we_run <= we_run + 1;
      end else if (!p_we) begin
        chk("cs_after_we", cs, 1'b0);
        chk("hold_stable", {adr_b, wd_b}, {p_adr, p_wd});
        last_we_len <= we_run;
        we_pulses   <= we_pulses + 1;
        we_run      <= 0;
      end
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", rd_valid, 1'b0);
        else begin
          chk("rd_data", rd_data, exp_q[0][3:0]);
          chk("rd_last", rd_last, exp_q[0][4]);
          void'(exp_q.pop_front());
        end
      end
    end else begin
      we_run <= 0;
    end
    p_we  <= we;
    p_cs  <= cs;
    p_adr <= adr_b;
    p_wd  <= wd_b;
  end

  // Strobe-width and read-pulse counters for the STROBE_CYC=3 instance.
  always @(negedge clkin) begin
    if (!rst_q) begin
      if (!we3) run3 <= run3 + 1;
      else if (run3 != 0) begin
        last3   <= run3;
        pulses3 <= pulses3 + 1;
        run3    <= 0;
      end
      if (rd_valid3) rdp3 <= rdp3 + 1;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clkin); #1;
      n++;
    end
    if (n >= 400) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic send_req(input logic wr, input logic [3:0] a, input logic [3:0] l);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_adr = a; req_len = l;
    while (!req_ready && n < 50) begin
      @(posedge clkin); #1;
      n++;
    end
    if (n >= 50) chk("req_timeout", req_ready, 1'b1);
    @(posedge clkin); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_wr_ready();
    int n = 0;
    while (!wr_ready && n < 50) begin
      @(posedge clkin); #1;
      n++;
    end
    if (n >= 50) chk("wr_ready_timeout", wr_ready, 1'b1);
  endtask

  task automatic write_burst(input logic [3:0] a, input logic [3:0] l,
                             input int stall_idx, input int stall_cyc);
    send_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      wait_wr_ready();
      if (i == stall_idx) begin
        for (int k = 0; k < stall_cyc; k++) begin
          chk("stall_cs", cs, 1'b1);
          chk("stall_we", we, 1'b1);
          @(posedge clkin); #1;
        end
      end
      wr_valid = 1'b1; wr_data = wbuf[i];
      @(posedge clkin); #1;
      wr_valid = 1'b0;
      exp_mem[a + 4'(i)] = wbuf[i];
    end
    wait_idle();
  endtask

  task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input bit lat);
    int n = 1;
    for (int i = 0; i <= int'(l); i++)
      exp_q.push_back({(i == int'(l)), exp_mem[a + 4'(i)]});
    send_req(1'b0, a, l);
    if (lat) begin
      while (!rd_valid && n < 10) begin
        @(posedge clkin); #1;
        n++;
      end
      chk("rd_latency", n, 3);
    end
    wait_idle();
    @(negedge clkin); #1;
    chk("rd_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int pulses0;
    reset = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_adr = 4'd0; req_len = 4'd0;
    wr_valid = 1'b0; wr_data = 4'd0;
    req_valid3 = 1'b0; req_wr3 = 1'b0; req_adr3 = 4'd0; req_len3 = 4'd0;
    wr_valid3 = 1'b0; wr_data3 = 4'd0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;

    repeat (2) @(posedge clkin);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 4'd0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cs_we", {cs, we}, 2'b11);
    chk("rst_adr_wd", {adr_b, wd_b}, 8'h00);
    reset = 1'b0;
    @(posedge clkin); #1;
`ifdef RAM16X4_CTL_INIT_EN
    pulses0 = we_pulses;
    @(posedge clkin); #1;
    chk("init_busy", busy, 1'b1);
    chk("init_req_ready", req_ready, 1'b0);
    wait_idle();
    @(negedge clkin); #1;
    chk("init_pulses", we_pulses - pulses0, 16);
    read_burst(4'd0, 4'd15, 1'b0);
`else
    chk("idle_req_ready", req_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
`endif

    // Single write then single read at address 5.
    pulses0 = we_pulses;
    wbuf[0] = 4'hA;
    write_burst(4'd5, 4'd0, -1, 0);
    chk("single_we_len", last_we_len, 1);
    chk("single_we_pulses", we_pulses - pulses0, 1);
    read_burst(4'd5, 4'd0, 1'b1);

    // Wrapping 8-word burst from address 12.
    for (int i = 0; i < 8; i++) wbuf[i] = 4'(i);
    write_burst(4'd12, 4'd7, -1, 0);
    read_burst(4'd12, 4'd7, 1'b0);

    // Write burst stalled 5 cycles before word 2.
    wbuf[0] = 4'h9; wbuf[1] = 4'h3; wbuf[2] = 4'hC; wbuf[3] = 4'h6;
    write_burst(4'd6, 4'd3, 2, 5);
    read_burst(4'd6, 4'd3, 1'b0);

    // Reset during the strobe of word 1 of a 4-word burst at address 10.
    send_req(1'b1, 4'd10, 4'd3);
    wbuf[0] = 4'hE; wbuf[1] = 4'hB;
    for (int i = 0; i < 2; i++) begin
      wait_wr_ready();
      wr_valid = 1'b1; wr_data = wbuf[i];
      @(posedge clkin); #1;
      wr_valid = 1'b0;
    end
    exp_mem[10] = 4'hE;
    n = 0;
    while (we && n < 10) begin
      @(posedge clkin); #1;
      n++;
    end
    chk("reach_strobe", we, 1'b0);
    reset = 1'b1;
    @(posedge clkin); #1;
    chk("abort_cs_we", {cs, we}, 2'b11);
    chk("abort_req_ready", req_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clkin); #1;
`ifdef RAM16X4_CTL_INIT_EN
    @(posedge clkin); #1;
    wait_idle();
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;
`else
    chk("abort_idle_ready", req_ready, 1'b1);
`endif
    read_burst(4'd10, 4'd0, 1'b1);
    read_burst(4'd12, 4'd7, 1'b0);
    read_burst(4'd5, 4'd0, 1'b0);
    read_burst(4'd6, 4'd1, 1'b0);

    // STROBE_CYC=3 instance: strobe width and request ignored while busy.
    wait (!busy3);
    #1;
    chk("u3_ready", req_ready3, 1'b1);
    req_valid3 = 1'b1; req_wr3 = 1'b1; req_adr3 = 4'd7; req_len3 = 4'd0;
    @(posedge clkin); #1;
    req_wr3 = 1'b0;
    n = 0;
    while (!wr_ready3 && n < 50) begin
      @(posedge clkin); #1;
      n++;
    end
    chk("u3_wr_ready", wr_ready3, 1'b1);
    wr_valid3 = 1'b1; wr_data3 = 4'h5;
    @(posedge clkin); #1;
    wr_valid3 = 1'b0;
    n = 0;
    while (busy3 && n < 50) begin
      chk("u3_no_accept", req_ready3, 1'b0);
      @(posedge clkin); #1;
      n++;
    end
    req_valid3 = 1'b0;
    chk("u3_idle", busy3, 1'b0);
    repeat (4) @(posedge clkin);
    #1;
    chk("u3_still_idle", busy3, 1'b0);
    chk("u3_no_read", rdp3, 0);
    chk("u3_we_len", last3, 3);
    chk("u3_we_pulses", pulses3, 1);
    chk("u3_adr_wd", {adr_b3, wd_b3}, 8'h75);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
